// File: rtl/convolution_processor_compstream.sv
// Two-stage stream comparator: S1 registers operands plus raw lt/eq flags,
// S2 evaluates the predicate and keeps per-frame min/max/hit statistics.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high; valid never depends on ready, and an offered output
// beat is held stable until it is taken.
module convolution_processor_compstream #(
  parameter int DATA_WIDTH = 13,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic [2:0]            op_i,
  input  logic                  signed_i,
  input  logic                  last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  result_o,
  output logic                  A_less_than_B_o,
  output logic                  A_equal_B_o,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o
);

  localparam int MSB = DATA_WIDTH - 1;

  // Stage 1 registers
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [2:0]            r_s1_op;
  logic                  r_s1_signed;
  logic                  r_s1_last;
  logic                  r_s1_lt;
  logic                  r_s1_eq;

  // Stage 2 (output) registers and frame state
  logic                  r_valid_o;
  logic                  r_result;
  logic                  r_lt;
  logic                  r_eq;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_first;

  logic                  w_s2_ready;
  logic                  w_s1_ready;
  logic                  w_s1_load;
  logic                  w_s2_load;
  logic [DATA_WIDTH-1:0] w_a_key;
  logic [DATA_WIDTH-1:0] w_b_key;
  logic                  w_lt;
  logic                  w_eq;
  logic                  w_pred;
  logic [DATA_WIDTH-1:0] w_s1a_key;
  logic [DATA_WIDTH-1:0] w_min_key;
  logic [DATA_WIDTH-1:0] w_max_key;
  logic [DATA_WIDTH-1:0] w_new_min;
  logic [DATA_WIDTH-1:0] w_new_max;
  logic [CNT_WIDTH-1:0]  w_new_cnt;

  assign w_s2_ready = ~r_valid_o | ready_i;
  assign w_s1_ready = ~r_s1_valid | w_s2_ready;
  assign ready_o    = w_s1_ready & ~clear_i;
  assign w_s1_load  = valid_i & ready_o;
  assign w_s2_load  = r_s1_valid & w_s2_ready;

  // Flipping the MSB maps two's complement order onto unsigned order.
  assign w_a_key = {A_i[MSB] ^ signed_i, A_i[MSB-1:0]};
  assign w_b_key = {B_i[MSB] ^ signed_i, B_i[MSB-1:0]};
  assign w_lt    = (w_a_key < w_b_key);
  assign w_eq    = (A_i == B_i);

  // Predicate select from the registered raw flags
  always_comb begin
    w_pred = 1'b0;
    case (r_s1_op)
      3'd0:    w_pred = r_s1_lt;
      3'd1:    w_pred = r_s1_lt | r_s1_eq;
      3'd2:    w_pred = r_s1_eq;
      3'd3:    w_pred = ~r_s1_eq;
      3'd4:    w_pred = ~r_s1_lt & ~r_s1_eq;
      3'd5:    w_pred = ~r_s1_lt;
      default: w_pred = 1'b0;
    endcase
  end

  // Min/max use the signedness of the beat being loaded.
  assign w_s1a_key = {r_s1_a[MSB] ^ r_s1_signed, r_s1_a[MSB-1:0]};
  assign w_min_key = {r_min[MSB] ^ r_s1_signed, r_min[MSB-1:0]};
  assign w_max_key = {r_max[MSB] ^ r_s1_signed, r_max[MSB-1:0]};

  // Next frame statistics; the first beat of a frame seeds them.
  always_comb begin
    w_new_min = r_min;
    w_new_max = r_max;
    w_new_cnt = r_cnt;
    if (r_first) begin
      w_new_min = r_s1_a;
      w_new_max = r_s1_a;
      w_new_cnt = CNT_WIDTH'(w_pred);
    end else begin
      if (w_s1a_key < w_min_key) w_new_min = r_s1_a;
      if (w_s1a_key > w_max_key) w_new_max = r_s1_a;
      if (!(&r_cnt)) w_new_cnt = r_cnt + CNT_WIDTH'(w_pred);
    end
  end

  // Stage 1: capture an accepted beat, release it when S2 takes it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_op     <= '0;
      r_s1_signed <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_lt     <= 1'b0;
      r_s1_eq     <= 1'b0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid  <= 1'b1;
      r_s1_a      <= A_i;
      r_s1_op     <= op_i;
      r_s1_signed <= signed_i;
      r_s1_last   <= last_i;
      r_s1_lt     <= w_lt;
      r_s1_eq     <= w_eq;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: load results and frame state, or retire the offered beat
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid_o <= 1'b0;
      r_result  <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_last    <= 1'b0;
      r_min     <= '0;
      r_max     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
    end else if (clear_i) begin
      r_valid_o <= 1'b0;
      r_result  <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_last    <= 1'b0;
      r_min     <= '0;
      r_max     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
    end else if (w_s2_load) begin
      r_valid_o <= 1'b1;
      r_result  <= w_pred;
      r_lt      <= r_s1_lt;
      r_eq      <= r_s1_eq;
      r_last    <= r_s1_last;
      r_min     <= w_new_min;
      r_max     <= w_new_max;
      r_cnt     <= w_new_cnt;
      r_first   <= r_s1_last;
    end else if (r_valid_o && ready_i) begin
      r_valid_o <= 1'b0;
    end
  end

  assign valid_o         = r_valid_o;
  assign result_o        = r_result;
  assign A_less_than_B_o = r_lt;
  assign A_equal_B_o     = r_eq;
  assign last_o          = r_last;
  assign min_o           = r_min;
  assign max_o           = r_max;
  assign hit_cnt_o       = r_cnt;

endmodule

// File: tb/tb_convolution_processor_compstream.sv
// Directed bench for the stream comparator: the driver pushes a hand-computed
// expected beat per issued input, a monitor pops and compares on each output
// transfer.
module tb_convolution_processor_compstream;

  localparam int DW = 13;
  localparam int CW = 2;
  localparam int EW = 4 + 2 * DW + CW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n_i;
  always #5 clk = ~clk;

  logic          clear_i, valid_i, ready_o, signed_i, last_i;
  logic [DW-1:0] A_i, B_i;
  logic [2:0]    op_i;
  logic          valid_o, ready_i, result_o, lt_o, eq_o, last_o;
  logic [DW-1:0] min_o, max_o;
  logic [CW-1:0] hit_cnt_o;

  convolution_processor_compstream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .A_i(A_i), .B_i(B_i), .op_i(op_i), .signed_i(signed_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .A_less_than_B_o(lt_o), .A_equal_B_o(eq_o), .last_o(last_o),
    .min_o(min_o), .max_o(max_o), .hit_cnt_o(hit_cnt_o)
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [EW-1:0] pack(input logic r, input logic lt, input logic eq,
                                         input logic l, input logic [DW-1:0] mn,
                                         input logic [DW-1:0] mx, input logic [CW-1:0] c);
    return {r, lt, eq, l, mn, mx, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an output transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n_i && valid_o && ready_i) begin
      logic [EW-1:0] act, exp;
      act = pack(result_o, lt_o, eq_o, last_o, min_o, max_o, hit_cnt_o);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_beat: unexpected beat %h with empty queue", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL out_beat: got r/lt/eq/last=%b%b%b%b min=%h max=%h cnt=%0d expected r/lt/eq/last=%b%b%b%b min=%h max=%h cnt=%0d",
                   act[EW-1], act[EW-2], act[EW-3], act[EW-4], act[2*DW+CW-1:DW+CW], act[DW+CW-1:CW], act[CW-1:0],
                   exp[EW-1], exp[EW-2], exp[EW-3], exp[EW-4], exp[2*DW+CW-1:DW+CW], exp[DW+CW-1:CW], exp[CW-1:0]);
        end
      end
    end
  end

  // Driver: offer one beat, wait (bounded) for acceptance, optionally push expectation
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                      input logic sg, input logic lst, input logic push,
                      input logic r, input logic lt, input logic eq,
                      input logic [DW-1:0] mn, input logic [DW-1:0] mx, input logic [CW-1:0] c);
    logic acc;
    int   cyc;
    if (push) exp_q.push_back(pack(r, lt, eq, lst, mn, mx, c));
    A_i = a; B_i = b; op_i = op; signed_i = sg; last_i = lst; valid_i = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no ready_o in %0d cycles expected acceptance", cyc);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    A_i = '0; B_i = '0; op_i = '0; signed_i = 1'b0; last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b1;
    @(negedge clk);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_flags", {28'd0, result_o, lt_o, eq_o, last_o}, 32'd0);
    chk("rst_min", 32'(min_o), 32'd0);
    chk("rst_max", 32'(max_o), 32'd0);
    chk("rst_cnt", 32'(hit_cnt_o), 32'd0);
    @(posedge clk); #1;

    // Single-beat frames across predicates and signedness
    send(13'd5,    13'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 13'd5,    13'd5,    2'd1);
    send(13'h1FFF, 13'd1, 3'd0, 1'b1, 1'b1, 1'b1, 1, 1, 0, 13'h1FFF, 13'h1FFF, 2'd1);
    send(13'h1FFF, 13'd1, 3'd0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 13'h1FFF, 13'h1FFF, 2'd0);
    send(13'h1FFF, 13'd1, 3'd4, 1'b0, 1'b1, 1'b1, 1, 0, 0, 13'h1FFF, 13'h1FFF, 2'd1);
    send(13'd7,    13'd7, 3'd1, 1'b0, 1'b1, 1'b1, 1, 0, 1, 13'd7,    13'd7,    2'd1);
    send(13'd7,    13'd7, 3'd3, 1'b0, 1'b1, 1'b1, 0, 0, 1, 13'd7,    13'd7,    2'd0);
    send(13'd2,    13'd9, 3'd5, 1'b0, 1'b1, 1'b1, 0, 1, 0, 13'd2,    13'd2,    2'd0);
    send(13'd1,    13'd1, 3'd6, 1'b0, 1'b1, 1'b1, 0, 0, 1, 13'd1,    13'd1,    2'd0);

    // Frame EQ statistics, then back-to-back next frame
    send(13'd9,  13'd3, 3'd2, 1'b0, 1'b0, 1'b1, 0, 0, 0, 13'd9, 13'd9,  2'd0);
    send(13'd3,  13'd3, 3'd2, 1'b0, 1'b0, 1'b1, 1, 0, 1, 13'd3, 13'd9,  2'd1);
    send(13'd12, 13'd3, 3'd2, 1'b0, 1'b0, 1'b1, 0, 0, 0, 13'd3, 13'd12, 2'd1);
    send(13'd3,  13'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1, 0, 1, 13'd3, 13'd12, 2'd2);
    send(13'd4,  13'd3, 3'd2, 1'b0, 1'b1, 1'b1, 0, 0, 0, 13'd4, 13'd4,  2'd0);

    // Signed min/max within a frame
    send(13'd5,    13'd0, 3'd4, 1'b1, 1'b0, 1'b1, 1, 0, 0, 13'd5,    13'd5, 2'd1);
    send(13'h1FFE, 13'd0, 3'd4, 1'b1, 1'b1, 1'b1, 0, 1, 0, 13'h1FFE, 13'd5, 2'd1);

    // Saturating hit counter
    send(13'd6, 13'd6, 3'd2, 1'b0, 1'b0, 1'b1, 1, 0, 1, 13'd6, 13'd6, 2'd1);
    send(13'd6, 13'd6, 3'd2, 1'b0, 1'b0, 1'b1, 1, 0, 1, 13'd6, 13'd6, 2'd2);
    send(13'd6, 13'd6, 3'd2, 1'b0, 1'b0, 1'b1, 1, 0, 1, 13'd6, 13'd6, 2'd3);
    send(13'd6, 13'd6, 3'd2, 1'b0, 1'b0, 1'b1, 1, 0, 1, 13'd6, 13'd6, 2'd3);
    send(13'd6, 13'd6, 3'd2, 1'b0, 1'b1, 1'b1, 1, 0, 1, 13'd6, 13'd6, 2'd3);

    // Backpressure: two beats buffer, the third stalls
    repeat (2) @(posedge clk);
    #1 ready_i = 1'b0;
    send(13'd20, 13'd15, 3'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 13'd20, 13'd20, 2'd0);
    send(13'd10, 13'd15, 3'd0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 13'd10, 13'd20, 2'd1);
    A_i = 13'd30; B_i = 13'd15; op_i = 3'd0; signed_i = 1'b0; last_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready_o", 32'(ready_o), 32'd0);
      chk("stall_valid_o", 32'(valid_o), 32'd1);
      chk("stall_min_max", {6'd0, min_o, max_o}, {6'd0, 13'd20, 13'd20});
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    send(13'd30, 13'd15, 3'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 13'd10, 13'd30, 2'd1);
    send(13'd5,  13'd15, 3'd0, 1'b0, 1'b1, 1'b1, 1, 1, 0, 13'd5,  13'd30, 2'd2);

    // Clear with two beats buffered mid-frame
    repeat (4) @(posedge clk);
    #1 ready_i = 1'b0;
    send(13'd50, 13'd1, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0, 13'd0, 13'd0, 2'd0);
    send(13'd60, 13'd1, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0, 13'd0, 13'd0, 2'd0);
    clear_i = 1'b1;
    @(negedge clk);
    chk("clear_ready_o", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1 clear_i = 1'b0;
    chk("clear_valid_o", 32'(valid_o), 32'd0);
    chk("clear_cnt", 32'(hit_cnt_o), 32'd0);
    chk("clear_min", 32'(min_o), 32'd0);
    ready_i = 1'b1;
    send(13'd8, 13'd8, 3'd2, 1'b0, 1'b1, 1'b1, 1, 0, 1, 13'd8, 13'd8, 2'd1);

    // Asynchronous reset mid-frame with a beat on the outputs
    repeat (3) @(posedge clk);
    #1 ready_i = 1'b0;
    send(13'd11, 13'd2, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0, 13'd0, 13'd0, 2'd0);
    @(posedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_valid_o", 32'(valid_o), 32'd0);
    chk("arst_flags", {28'd0, result_o, lt_o, eq_o, last_o}, 32'd0);
    chk("arst_min_max", {6'd0, min_o, max_o}, 32'd0);
    chk("arst_cnt", 32'(hit_cnt_o), 32'd0);
    chk("arst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 rst_n_i = 1'b1; ready_i = 1'b1;
    send(13'd4, 13'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1, 0, 1, 13'd4, 13'd4, 2'd1);

    // Drain
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
